// File: rtl/hsid_pkg.sv
// Shared HSID constants: pixel/word widths and grant LFSR definition.
// No logic; constants and a pure helper function only.
// Not applicable (no flow control).
package hsid_pkg;

    localparam int HSID_WORD_WIDTH = 32;
    localparam int HSID_DATA_WIDTH = 16;

    // x^16 + x^14 + x^13 + x^11 + 1, taps on state bits 15,13,12,10 (shift-left form)
    localparam logic [15:0] HSID_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] HSID_LFSR_SEED = 16'hACE1;

    // One Fibonacci step: parity of the tapped bits enters at bit 0
    function automatic logic [15:0] hsid_lfsr_next(input logic [15:0] state);
        return {state[14:0], ^(state & HSID_LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/hsid_x_obi_inf_pkg.sv
// OBI request/response bundles used by the HSID memory models.
// No logic; type definitions only.
// gnt/rvalid handshake; no rready, responses never stall.
package hsid_x_obi_inf_pkg;

    import hsid_pkg::*;

    localparam int OBI_AW  = HSID_WORD_WIDTH;
    localparam int OBI_DW  = HSID_WORD_WIDTH;
    localparam int OBI_BEW = HSID_WORD_WIDTH / 8;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [OBI_BEW-1:0] be;
        logic [OBI_AW-1:0] addr;
        logic [OBI_DW-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic              gnt;
        logic              rvalid;
        logic [OBI_DW-1:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/hsp_obi_rsp_delay.sv
// Fixed-depth shift register carrying {valid, data} from accept to response.
// Latency: exactly DEPTH cycles from head to tail.
// Never stalls; every entry advances each cycle.
module hsp_obi_rsp_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] tail
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift every cycle; reset wipes in-flight responses so none survive it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= head;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tail = stage_q[DEPTH-1];

endmodule

// File: rtl/hsp_obi_mem_pipe.sv
// OBI slave memory model: pattern/stored reads, fixed RD_LATENCY, bounded in-flight count.
// Latency: gnt combinational, rvalid exactly RD_LATENCY cycles after accept.
// Backpressure via gnt only (outstanding limit, optional LFSR); write store under HSP_OBI_MEM_PIPE_WRITE_EN.
module hsp_obi_mem_pipe
    import hsid_pkg::*;
#(
    parameter int          WORD_WIDTH      = HSID_WORD_WIDTH,
    parameter int          DATA_WIDTH      = HSID_DATA_WIDTH,
    parameter logic [31:0] VALUE_MASK      = 32'h00003FFF,
    parameter int          RD_LATENCY      = 1,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [15:0] LFSR_SEED       = HSID_LFSR_SEED,
    parameter int          MEM_DEPTH       = 256
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  hsid_x_obi_inf_pkg::obi_req_t           obi_req,
    output hsid_x_obi_inf_pkg::obi_resp_t          obi_rsp,
    input  logic                                   random_gnt,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

    localparam int P  = WORD_WIDTH / DATA_WIDTH;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    if (WORD_WIDTH % DATA_WIDTH != 0) begin : g_bad_width
        $error("WORD_WIDTH must be a multiple of DATA_WIDTH");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_lat
        $error("RD_LATENCY must be 1..8");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > RD_LATENCY) begin : g_bad_max
        $error("MAX_OUTSTANDING must be 1..RD_LATENCY");
    end
    if (MEM_DEPTH < 1 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("MEM_DEPTH must be a power of two");
    end

    logic [15:0]           lfsr_q;
    logic [CW-1:0]         cnt_q;
    logic                  slot_free;
    logic                  gnt;
    logic                  rsp_vld;
    logic [WORD_WIDTH-1:0] rsp_dat;
    logic [WORD_WIDTH-1:0] pattern;
    logic [WORD_WIDTH-1:0] read_dat;

    // Free-running grant LFSR, advances whether or not a request is present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= hsid_lfsr_next(lfsr_q);
        end
    end

    // A response leaving this cycle frees its slot now, so accept and retire can overlap
    assign slot_free = (cnt_q < CW'(MAX_OUTSTANDING)) | rsp_vld;
    assign gnt       = rst_n & obi_req.req & slot_free & (random_gnt ? lfsr_q[0] : 1'b1);

    // In-flight count: +1 on accept, -1 on response, unchanged when both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (gnt && !rsp_vld) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (!gnt && rsp_vld) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Read pattern: address pixel fields in reversed slot order, each masked
    always_comb begin
        pattern = '0;
        for (int k = 0; k < P; k++) begin
            pattern[k*DATA_WIDTH +: DATA_WIDTH] =
                obi_req.addr[(P-1-k)*DATA_WIDTH +: DATA_WIDTH] & VALUE_MASK[DATA_WIDTH-1:0];
        end
    end

`ifdef HSP_OBI_MEM_PIPE_WRITE_EN
    localparam int IW = $clog2(MEM_DEPTH);

    logic [WORD_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]  wvld_q;
    logic [IW-1:0]         idx;
    logic [WORD_WIDTH-1:0] stored;
    logic [WORD_WIDTH-1:0] merged;

    assign idx    = obi_req.addr[IW+1:2];
    assign stored = wvld_q[idx] ? mem_q[idx] : pattern;

    // Partial writes to a never-written word merge over its pattern value
    always_comb begin
        merged = stored;
        for (int b = 0; b < WORD_WIDTH / 8; b++) begin
            if (obi_req.be[b]) begin
                merged[b*8 +: 8] = obi_req.wdata[b*8 +: 8];
            end
        end
    end

    // Store contents carry no reset; the valid bits decide whether they are used
    always_ff @(posedge clk) begin
        if (gnt && obi_req.we) begin
            mem_q[idx] <= merged;
        end
    end

    // Per-word valid bits, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wvld_q <= '0;
        end else if (gnt && obi_req.we) begin
            wvld_q[idx] <= 1'b1;
        end
    end

    assign read_dat = obi_req.we ? '0 : stored;
`else
    logic unused_req;

    assign unused_req = ^{obi_req.be, obi_req.wdata};
    assign read_dat   = obi_req.we ? '0 : pattern;
`endif

    hsp_obi_rsp_delay #(
        .DEPTH (RD_LATENCY),
        .WIDTH (WORD_WIDTH + 1)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .head  ({gnt, gnt ? read_dat : {WORD_WIDTH{1'b0}}}),
        .tail  ({rsp_vld, rsp_dat})
    );

    // Response bundle; rdata forced to zero outside rvalid
    always_comb begin
        obi_rsp        = '0;
        obi_rsp.gnt    = gnt;
        obi_rsp.rvalid = rsp_vld;
        obi_rsp.rdata  = rsp_vld ? rsp_dat : '0;
    end

    assign outstanding = cnt_q;

endmodule

// File: tb/tb_hsp_obi_mem_pipe.sv
// Scoreboard bench: driver predicts gnt/outstanding and queues expected responses.
// Monitor pops and compares on every rvalid, independent of the driver.
// Reference model works from accept times and address arithmetic only.
module tb_hsp_obi_mem_pipe;

    import hsid_pkg::*;
    import hsid_x_obi_inf_pkg::*;

    localparam int          LAT  = 4;
    localparam int          MAXO = 2;
    localparam int          CW   = $clog2(MAXO + 1);
    localparam int          DW   = HSID_DATA_WIDTH;
    localparam int          P    = HSID_WORD_WIDTH / DW;
    localparam logic [31:0] MASK = 32'h00003FFF;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          random_gnt = 1'b0;
    obi_req_t      bus_req = '0;
    obi_resp_t     bus_rsp;
    logic [CW-1:0] outstanding;

    always #5 clk = ~clk;

    hsp_obi_mem_pipe #(
        .RD_LATENCY      (LAT),
        .MAX_OUTSTANDING (MAXO),
        .LFSR_SEED       (SEED)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .obi_req     (bus_req),
        .obi_rsp     (bus_rsp),
        .random_gnt  (random_gnt),
        .outstanding (outstanding)
    );

    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          grants = 0;
    exp_t        sb[$];
    int          due_q[$];
    int          model_cnt = 0;
    logic [15:0] model_lfsr = SEED;
    logic [31:0] model_mem [logic [7:0]];
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Polynomial x^16+x^14+x^13+x^11+1 applied to a left-shifting register
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    function automatic logic [31:0] pat(input logic [31:0] a);
        logic [31:0] r;
        logic [31:0] f;
        r = '0;
        for (int k = 0; k < P; k++) begin
            f = (a >> ((P - 1 - k) * DW)) & MASK & ((32'h1 << DW) - 32'h1);
            r = r | (f << (k * DW));
        end
        return r;
    endfunction

    function automatic logic [31:0] model_rdata(input logic w, input logic [3:0] be,
                                                input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] base;
        base = pat(a);
`ifdef HSP_OBI_MEM_PIPE_WRITE_EN
        if (model_mem.exists(a[9:2])) base = model_mem[a[9:2]];
        if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) base[b*8 +: 8] = wd[b*8 +: 8];
            end
            model_mem[a[9:2]] = base;
        end
`endif
        return w ? 32'h0 : base;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 15)) << 2;
        return $urandom;
    endfunction

    // One clock cycle: entered and left at negedge+1
    task automatic step(input logic r, input logic w, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd, input logic rg,
                        output logic g);
        logic exp_g;
        logic rv_now;
        bus_req.req   = r;
        bus_req.we    = w;
        bus_req.be    = be;
        bus_req.addr  = a;
        bus_req.wdata = wd;
        random_gnt    = rg;
        #2;
        rv_now = (due_q.size() > 0) && (due_q[0] == cyc);
        exp_g  = r && ((model_cnt - int'(rv_now)) < MAXO) && (rg ? model_lfsr[0] : 1'b1);
        check("gnt", bus_rsp.gnt, exp_g);
        check("outstanding", outstanding, model_cnt);
        g = bus_rsp.gnt;
        if (exp_g) begin
            sb.push_back('{due: cyc + LAT, dat: model_rdata(w, be, a, wd)});
            due_q.push_back(cyc + LAT);
            grants++;
        end
        model_cnt = model_cnt + int'(exp_g) - int'(rv_now);
        if (rv_now) void'(due_q.pop_front());
        model_lfsr = lfsr_step(model_lfsr);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic g;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, $urandom, $urandom, 1'b0, g);
    endtask

    task automatic rand_op(input logic rg, input logic force_read);
        logic g;
        logic r;
        logic w;
        r = force_read ? 1'b1 : ($urandom_range(0, 3) != 0);
        w = force_read ? 1'b0 : ($urandom_range(0, 2) == 0);
        step(r, w, 4'($urandom), rand_addr(), $urandom, rg, g);
    endtask

    // Reset with req held high: gnt must stay low, all state cleared
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        bus_req.req = 1'b1;
        random_gnt  = 1'b0;
        sb.delete();
        due_q.delete();
        model_mem.delete();
        model_cnt  = 0;
        model_lfsr = SEED;
        for (int i = 0; i < n; i++) begin
            #2;
            check("rst_gnt", bus_rsp.gnt, 1'b0);
            check("rst_outstanding", outstanding, 0);
            check("rst_rvalid", bus_rsp.rvalid, 1'b0);
            check("rst_rdata", bus_rsp.rdata, 32'h0);
            @(negedge clk);
            #1;
        end
        rst_n = 1'b1;
        bus_req.req = 1'b0;
    endtask

    // Monitor: every rvalid must match the oldest expected response at its due cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_rsp.rvalid) begin
                if (sb.size() == 0) begin
                    check("rvalid_without_grant", bus_rsp.rvalid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rvalid_cycle", cyc, mon_e.due);
                    check("rdata", bus_rsp.rdata, mon_e.dat);
                end
            end else begin
                check("rdata_idle", bus_rsp.rdata, 32'h0);
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    check("missing_rvalid", bus_rsp.rvalid, 1'b1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic       g;
        logic [7:0] held_pat;
        int         rg_grants;

        @(negedge clk);
        #1;
        do_reset(3);

        // Single read, pattern swaps the two pixel fields
        step(1'b1, 1'b0, 4'hF, 32'h0001_0002, 32'h0, 1'b0, g);
        check("single_gnt", g, 1'b1);
        idle(LAT + 1);

        // Request held 8 cycles against a 2-deep limit with 4-cycle latency
        held_pat = 8'b0011_0011;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 4'hF, rand_addr(), 32'h0, 1'b0, g);
            check("gnt_held", g, held_pat[i]);
        end
        idle(LAT + 2);

`ifdef HSP_OBI_MEM_PIPE_WRITE_EN
        // Partial write to an unwritten word merges over its pattern, then read it back
        step(1'b1, 1'b1, 4'b0011, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, g);
        idle(LAT);
        step(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b0, g);
        idle(LAT + 1);
        // Write followed immediately by a read of the same word
        step(1'b1, 1'b1, 4'b1100, 32'h0000_0020, 32'h1234_5678, 1'b0, g);
        step(1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0, 1'b0, g);
        idle(LAT + 1);
`endif

        // Randomized mix of reads and writes, grant whenever allowed
        for (int i = 0; i < 200; i++) rand_op(1'b0, 1'b0);
        idle(LAT + 2);

        // 100 reads with pseudo-random grant
        rg_grants = grants;
        for (int i = 0; i < 100; i++) rand_op(1'b1, 1'b1);
        idle(LAT + 2);
        check("random_grants_seen", (grants - rg_grants) > 0, 1'b1);

        // Reset one cycle after two accepts: those responses must never appear
        step(1'b1, 1'b0, 4'hF, rand_addr(), 32'h0, 1'b0, g);
        step(1'b1, 1'b0, 4'hF, rand_addr(), 32'h0, 1'b0, g);
        idle(1);
        do_reset(2);
        idle(LAT + 3);

        // More random traffic after reset, then drain
        for (int i = 0; i < 60; i++) rand_op(1'($urandom_range(0, 1)), 1'b0);
        idle(LAT + 2);

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
